// File: rtl/display_buffer_pkg.sv
// ============================================================================
// display_buffer_pkg : shared FSM encoding, ctrl bit indices, status layout
// Revision: 1.0
// ============================================================================
`default_nettype none

package display_buffer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    localparam int CTRL_WR      = 0;
    localparam int CTRL_SWAP    = 1;
    localparam int CTRL_CLR     = 2;
    localparam int CTRL_CLR_ERR = 7;

    localparam int STAT_BUSY      = 0;
    localparam int STAT_SWAP_PEND = 1;
    localparam int STAT_ERR_DROP  = 2;
    localparam int STAT_FRONT     = 3;

endpackage

`default_nettype wire

// File: rtl/pio_edge_detect.sv
// ============================================================================
// pio_edge_detect : registers a level vector and flags per-bit 0->1 edges
// Revision: 1.0
// ============================================================================
`default_nettype none

module pio_edge_detect #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_level,
    output logic [WIDTH-1:0] o_rise
);

    logic [WIDTH-1:0] r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= '0;
        end else begin
            r_prev <= i_level;
        end
    end

    assign o_rise = i_level & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/display_buffer_seq.sv
// ============================================================================
// display_buffer_seq : double-buffered pixel RAM write sequencer with swap
// Optional bank clear compiled in by DISPLAY_BUFFER_CLEAR_EN.  Revision: 1.0
// ============================================================================
`default_nettype none

module display_buffer_seq
    import display_buffer_pkg::*;
#(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [ADDR_W-1:0] pio_addr_i,
    input  logic [DATA_W-1:0] pio_data_i,
    input  logic [7:0]        pio_ctrl_i,
    input  logic              frame_done_i,
    output logic              ram_we_o,
    output logic [ADDR_W:0]   ram_addr_o,
    output logic [DATA_W-1:0] ram_data_o,
    output logic              front_bank_o,
    output logic [7:0]        status_o
);

    state_t            r_state, w_state_nxt;
    logic              r_we, w_we_nxt;
    logic [ADDR_W:0]   r_addr, w_addr_nxt;
    logic [DATA_W-1:0] r_data, w_data_nxt;
    logic              r_front, w_front_nxt;
    logic              r_swap_pend, w_swap_pend_nxt;
    logic              r_err, w_err_nxt;
    logic              w_swap_go;
    logic [7:0]        w_rise;
    logic              w_unused_ctrl;
`ifdef DISPLAY_BUFFER_CLEAR_EN
    logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;
`endif

    pio_edge_detect #(
        .WIDTH (8)
    ) u_edge (
        .clk     (clk_clk),
        .rst_n   (reset_reset_n),
        .i_level (pio_ctrl_i),
        .o_rise  (w_rise)
    );

`ifdef DISPLAY_BUFFER_CLEAR_EN
    assign w_unused_ctrl = |w_rise[6:3];
`else
    assign w_unused_ctrl = |w_rise[6:2];
`endif

    // Swap uses the registered pending flag, so a request edge cannot be
    // consumed by a frame_done in the same cycle.
    assign w_swap_go = frame_done_i && r_swap_pend && (r_state != ST_CLEAR);

    always_comb begin
        w_state_nxt     = r_state;
        w_we_nxt        = 1'b0;
        w_addr_nxt      = '0;
        w_data_nxt      = '0;
        w_front_nxt     = r_front;
        w_swap_pend_nxt = r_swap_pend;
        w_err_nxt       = r_err;
`ifdef DISPLAY_BUFFER_CLEAR_EN
        w_cnt_nxt       = r_cnt;
`endif

        if (w_swap_go) begin
            w_front_nxt     = ~r_front;
            w_swap_pend_nxt = 1'b0;
        end
        if (w_rise[CTRL_SWAP]) begin
            w_swap_pend_nxt = 1'b1;
        end
        if (w_rise[CTRL_CLR_ERR]) begin
            w_err_nxt = 1'b0;
        end

        case (r_state)
            ST_IDLE: begin
                // Writes target the back bank as seen before any same-cycle swap.
                if (w_rise[CTRL_WR]) begin
                    w_state_nxt = ST_WRITE;
                    w_we_nxt    = 1'b1;
                    w_addr_nxt  = {~r_front, pio_addr_i};
                    w_data_nxt  = pio_data_i;
                end
`ifdef DISPLAY_BUFFER_CLEAR_EN
                else if (w_rise[CTRL_CLR]) begin
                    w_state_nxt = ST_CLEAR;
                    w_we_nxt    = 1'b1;
                    w_addr_nxt  = {~w_front_nxt, {ADDR_W{1'b0}}};
                    w_cnt_nxt   = '0;
                end
`endif
            end
            ST_WRITE: begin
                w_state_nxt = ST_IDLE;
                if (w_rise[CTRL_WR]) begin
                    w_err_nxt = 1'b1;
                end
            end
`ifdef DISPLAY_BUFFER_CLEAR_EN
            ST_CLEAR: begin
                if (w_rise[CTRL_WR]) begin
                    w_err_nxt = 1'b1;
                end
                if (r_cnt == {ADDR_W{1'b1}}) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt  = r_cnt + 1'b1;
                    w_we_nxt   = 1'b1;
                    w_addr_nxt = {r_addr[ADDR_W], r_cnt + 1'b1};
                end
            end
`endif
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state     <= ST_IDLE;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
            r_front     <= 1'b0;
            r_swap_pend <= 1'b0;
            r_err       <= 1'b0;
`ifdef DISPLAY_BUFFER_CLEAR_EN
            r_cnt       <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_we        <= w_we_nxt;
            r_addr      <= w_addr_nxt;
            r_data      <= w_data_nxt;
            r_front     <= w_front_nxt;
            r_swap_pend <= w_swap_pend_nxt;
            r_err       <= w_err_nxt;
`ifdef DISPLAY_BUFFER_CLEAR_EN
            r_cnt       <= w_cnt_nxt;
`endif
        end
    end

    always_comb begin
        status_o                 = '0;
        status_o[STAT_BUSY]      = (r_state != ST_IDLE);
        status_o[STAT_SWAP_PEND] = r_swap_pend;
        status_o[STAT_ERR_DROP]  = r_err;
        status_o[STAT_FRONT]     = r_front;
    end

    assign ram_we_o     = r_we;
    assign ram_addr_o   = r_addr;
    assign ram_data_o   = r_data;
    assign front_bank_o = r_front;

endmodule

`default_nettype wire

// File: tb/tb_display_buffer_seq.sv
// ============================================================================
// tb_display_buffer_seq : directed self-checking bench, ADDR_W=11 and ADDR_W=4
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_display_buffer_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] pio_addr = '0;
    logic [31:0] pio_data = '0;
    logic [7:0]  pio_ctrl = '0;
    logic        fd = 1'b0;

    logic        we11, front11;
    logic [11:0] addr11;
    logic [31:0] data11;
    logic [7:0]  st11;
    logic        we4, front4;
    logic [4:0]  addr4;
    logic [31:0] data4;
    logic [7:0]  st4;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    display_buffer_seq u_dut11 (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .pio_addr_i    (pio_addr),
        .pio_data_i    (pio_data),
        .pio_ctrl_i    (pio_ctrl),
        .frame_done_i  (fd),
        .ram_we_o      (we11),
        .ram_addr_o    (addr11),
        .ram_data_o    (data11),
        .front_bank_o  (front11),
        .status_o      (st11)
    );

    display_buffer_seq #(.ADDR_W(4), .DATA_W(32)) u_dut4 (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .pio_addr_i    (pio_addr[3:0]),
        .pio_data_i    (pio_data),
        .pio_ctrl_i    (pio_ctrl),
        .frame_done_i  (fd),
        .ram_we_o      (we4),
        .ram_addr_o    (addr4),
        .ram_data_o    (data4),
        .front_bank_o  (front4),
        .status_o      (st4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        tests++;
        if ({we11, addr11, data11, st11, front11} !== '0) begin
            fails++;
            $display("FAIL reset_dut11: we=%b addr=%h data=%h st=%h front=%b, want all 0",
                     we11, addr11, data11, st11, front11);
        end
        tests++;
        if ({we4, addr4, data4, st4, front4} !== '0) begin
            fails++;
            $display("FAIL reset_dut4: we=%b addr=%h data=%h st=%h, want all 0", we4, addr4, data4, st4);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_write();
        pio_addr = 11'h005;
        pio_data = 32'hDEADBEEF;
        pio_ctrl = 8'h01;
        @(negedge clk);
        tests++;
        if (we11 !== 1'b0) begin
            fails++;
            $display("FAIL write_early: we=%b want 0", we11);
        end
        tick();
        tests++;
        if ({we11, addr11, data11, st11[0]} !== {1'b1, 12'h805, 32'hDEADBEEF, 1'b1}) begin
            fails++;
            $display("FAIL write_pulse: we=%b addr=%h data=%h busy=%b want 1 805 deadbeef 1",
                     we11, addr11, data11, st11[0]);
        end
        tests++;
        if ({we4, addr4} !== {1'b1, 5'h15}) begin
            fails++;
            $display("FAIL write_dut4: we=%b addr=%h want 1 15", we4, addr4);
        end
        tick();
        tests++;
        if ({we11, addr11, data11, st11[0]} !== '0) begin
            fails++;
            $display("FAIL write_end: we=%b addr=%h data=%h busy=%b want all 0",
                     we11, addr11, data11, st11[0]);
        end
        pio_ctrl = 8'h00;
        tick();
    endtask

    task automatic test_held_strobe();
        int n = 0;
        pio_ctrl = 8'h01;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (we11 === 1'b1) n++;
        end
        tests++;
        if (n != 1) begin
            fails++;
            $display("FAIL held_strobe: pulses=%0d want 1", n);
        end
        pio_ctrl = 8'h00;
        tick();
    endtask

    task automatic test_swap();
        pio_ctrl = 8'h02;
        tick();
        pio_ctrl = 8'h00;
        tests++;
        if (st11[1] !== 1'b1) begin
            fails++;
            $display("FAIL swap_pending_set: pend=%b want 1", st11[1]);
        end
        repeat (4) tick();
        fd = 1'b1;
        @(negedge clk);
        tests++;
        if (front11 !== 1'b0) begin
            fails++;
            $display("FAIL swap_early: front=%b want 0", front11);
        end
        tick();
        fd = 1'b0;
        tests++;
        if ({front11, st11[3], st11[1]} !== 3'b110) begin
            fails++;
            $display("FAIL swap_toggle: front=%b st_front=%b pend=%b want 1 1 0", front11, st11[3], st11[1]);
        end
        // request edge coincident with frame_done is not consumed
        pio_ctrl = 8'h02;
        fd = 1'b1;
        tick();
        pio_ctrl = 8'h00;
        fd = 1'b0;
        tests++;
        if ({front11, st11[1]} !== 2'b11) begin
            fails++;
            $display("FAIL swap_coincident: front=%b pend=%b want 1 1", front11, st11[1]);
        end
        tick();
        fd = 1'b1;
        tick();
        fd = 1'b0;
        tests++;
        if ({front11, st11[1], front4} !== 3'b000) begin
            fails++;
            $display("FAIL swap_second: front=%b pend=%b front4=%b want 0 0 0", front11, st11[1], front4);
        end
    endtask

    task automatic test_swap_with_write();
        pio_ctrl = 8'h02;
        tick();
        pio_ctrl = 8'h00;
        tick();
        pio_addr = 11'h00A;
        pio_data = 32'h12345678;
        pio_ctrl = 8'h01;
        fd = 1'b1;
        tick();
        pio_ctrl = 8'h00;
        fd = 1'b0;
        tests++;
        if ({we11, addr11, data11, front11} !== {1'b1, 12'h80A, 32'h12345678, 1'b1}) begin
            fails++;
            $display("FAIL swap_write: we=%b addr=%h data=%h front=%b want 1 80a 12345678 1",
                     we11, addr11, data11, front11);
        end
        tests++;
        if (addr4 !== 5'h1A) begin
            fails++;
            $display("FAIL swap_write_dut4: addr=%h want 1a", addr4);
        end
        tick();
    endtask

    task automatic test_async_reset();
        pio_ctrl = 8'h02;
        tick();
        pio_ctrl = 8'h00;
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({st11, st4, front11, front4} !== '0) begin
            fails++;
            $display("FAIL async_reset: st11=%h st4=%h front=%b%b want 0", st11, st4, front11, front4);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_idle11(input string name);
        int k = 0;
        while (st11[0] !== 1'b0 && k < 3000) begin
            tick();
            k++;
        end
        tests++;
        if (st11[0] !== 1'b0) begin
            fails++;
            $display("FAIL %s: busy=%b still set after %0d cycles", name, st11[0], k);
        end
    endtask

`ifdef DISPLAY_BUFFER_CLEAR_EN
    task automatic test_clear();
        pio_ctrl = 8'h04;
        tick();
        pio_ctrl = 8'h00;
        tests++;
        if ({we11, addr11} !== {1'b1, 12'h800}) begin
            fails++;
            $display("FAIL clear11_first: we=%b addr=%h want 1 800", we11, addr11);
        end
        for (int i = 0; i < 16; i++) begin
            tests++;
            if ({we4, addr4, data4, st4[0]} !== {1'b1, 1'b1, 4'(i), 32'h0, 1'b1}) begin
                fails++;
                $display("FAIL clear_word%0d: we=%b addr=%h data=%h busy=%b want 1 %h 0 1",
                         i, we4, addr4, data4, st4[0], 5'h10 + 5'(i));
            end
            if (i == 5) pio_ctrl = 8'h01;
            if (i == 6) pio_ctrl = 8'h00;
            tick();
        end
        tests++;
        if ({we4, addr4, data4, st4[0], st4[2], st11[2]} !== {1'b0, 5'h0, 32'h0, 1'b0, 1'b1, 1'b1}) begin
            fails++;
            $display("FAIL clear_done: we=%b addr=%h busy=%b err4=%b err11=%b want 0 0 0 1 1",
                     we4, addr4, st4[0], st4[2], st11[2]);
        end
        pio_ctrl = 8'h80;
        tick();
        pio_ctrl = 8'h00;
        tests++;
        if ({st4[2], st11[2]} !== 2'b00) begin
            fails++;
            $display("FAIL err_clear: err4=%b err11=%b want 0 0", st4[2], st11[2]);
        end
        wait_idle11("clear11_timeout");
    endtask

    task automatic test_swap_during_clear();
        int k = 0;
        pio_ctrl = 8'h02;
        tick();
        pio_ctrl = 8'h04;
        tick();
        pio_ctrl = 8'h00;
        tick();
        tick();
        fd = 1'b1;
        tick();
        fd = 1'b0;
        tests++;
        if ({front4, st4[1], st4[0]} !== 3'b011) begin
            fails++;
            $display("FAIL swap_in_clear: front=%b pend=%b busy=%b want 0 1 1", front4, st4[1], st4[0]);
        end
        while (st4[0] !== 1'b0 && k < 40) begin
            tick();
            k++;
        end
        fd = 1'b1;
        tick();
        fd = 1'b0;
        tests++;
        if ({front4, st4[1]} !== 2'b10) begin
            fails++;
            $display("FAIL swap_after_clear: front=%b pend=%b want 1 0", front4, st4[1]);
        end
        wait_idle11("clear11_swap_timeout");
        fd = 1'b1;
        tick();
        fd = 1'b0;
        tests++;
        if ({front11, st11[1], front4} !== 3'b101) begin
            fails++;
            $display("FAIL swap_after_clear11: front11=%b pend11=%b front4=%b want 1 0 1",
                     front11, st11[1], front4);
        end
    endtask

    task automatic test_reset_mid_clear();
        int n = 0;
        pio_ctrl = 8'h04;
        tick();
        pio_ctrl = 8'h00;
        repeat (7) tick();
        tests++;
        if ({we4, addr4} !== {1'b1, 5'h07}) begin
            fails++;
            $display("FAIL clear_word7: we=%b addr=%h want 1 07", we4, addr4);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({we4, addr4, data4, st4, front4, we11, addr11, st11} !== '0) begin
            fails++;
            $display("FAIL reset_mid_clear: we4=%b addr4=%h st4=%h we11=%b addr11=%h st11=%h want 0",
                     we4, addr4, st4, we11, addr11, st11);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (we4 !== 1'b0 || we11 !== 1'b0) n++;
        end
        tests++;
        if (n != 0) begin
            fails++;
            $display("FAIL no_resume: write cycles=%0d want 0", n);
        end
    endtask
`else
    task automatic test_clear_disabled();
        int n = 0;
        pio_ctrl = 8'h04;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (we4 !== 1'b0 || st4[0] !== 1'b0 || we11 !== 1'b0 || st11[0] !== 1'b0) n++;
        end
        pio_ctrl = 8'h00;
        tick();
        tests++;
        if (n != 0) begin
            fails++;
            $display("FAIL clear_disabled: active cycles=%0d want 0", n);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_held_strobe();
        test_swap();
        test_swap_with_write();
        test_async_reset();
`ifdef DISPLAY_BUFFER_CLEAR_EN
        test_clear();
        test_swap_during_clear();
        test_reset_mid_clear();
`else
        test_clear_disabled();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
